// File: rtl/enc66_to_8b10b_inj.sv
// rtl/enc66_to_8b10b_inj.sv - 64-bit payload to eight chained 8b/10b symbols, with bit-flip injection copy and disparity checker.
// Optional macro ERR_INJ_EN enables the LFSR-driven single-bit error injection.
module enc66_to_8b10b_inj #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [65:0] din_66b,
    input  logic        kin,
    input  logic        error_injection_enable,
    output logic [79:0] dout_8b10,
    output logic        disp_err,
    output logic        kin_err,
    output logic [79:0] corrupted_data
);

    // RD- forms of the 5b/6b data codes (abcdei, a in the MSB)
    function automatic logic [5:0] enc6(input logic [4:0] x);
        case (x)
            5'd0:  enc6 = 6'b100111;  5'd1:  enc6 = 6'b011101;
            5'd2:  enc6 = 6'b101101;  5'd3:  enc6 = 6'b110001;
            5'd4:  enc6 = 6'b110101;  5'd5:  enc6 = 6'b101001;
            5'd6:  enc6 = 6'b011001;  5'd7:  enc6 = 6'b111000;
            5'd8:  enc6 = 6'b111001;  5'd9:  enc6 = 6'b100101;
            5'd10: enc6 = 6'b010101;  5'd11: enc6 = 6'b110100;
            5'd12: enc6 = 6'b001101;  5'd13: enc6 = 6'b101100;
            5'd14: enc6 = 6'b011100;  5'd15: enc6 = 6'b010111;
            5'd16: enc6 = 6'b011011;  5'd17: enc6 = 6'b100011;
            5'd18: enc6 = 6'b010011;  5'd19: enc6 = 6'b110010;
            5'd20: enc6 = 6'b001011;  5'd21: enc6 = 6'b101010;
            5'd22: enc6 = 6'b011010;  5'd23: enc6 = 6'b111010;
            5'd24: enc6 = 6'b110011;  5'd25: enc6 = 6'b100110;
            5'd26: enc6 = 6'b010110;  5'd27: enc6 = 6'b110110;
            5'd28: enc6 = 6'b001110;  5'd29: enc6 = 6'b101110;
            5'd30: enc6 = 6'b011110;  default: enc6 = 6'b101011;
        endcase
    endfunction

    function automatic logic [3:0] enc4(input logic [2:0] y, input logic is_k);
        case (y)
            3'd0:    enc4 = 4'b1011;
            3'd1:    enc4 = is_k ? 4'b0110 : 4'b1001;
            3'd2:    enc4 = is_k ? 4'b1010 : 4'b0101;
            3'd3:    enc4 = 4'b1100;
            3'd4:    enc4 = 4'b1101;
            3'd5:    enc4 = is_k ? 4'b0101 : 4'b1010;
            3'd6:    enc4 = is_k ? 4'b1001 : 4'b0110;
            default: enc4 = is_k ? 4'b0111 : 4'b1110;
        endcase
    endfunction

    logic        rd_q;
    logic [79:0] enc_word;
    logic        enc_rd;
    logic        enc_kerr;
    logic [7:0]  b_v;
    logic [4:0]  x_v;
    logic [2:0]  y_v;
    logic        klegal_v;
    logic        isk_v;
    logic        a7_v;
    logic [5:0]  six_v;
    logic [3:0]  four_v;
    logic        six_bal;
    logic        four_bal;

    always_comb begin
        enc_word = '0;
        enc_rd   = rd_q;
        enc_kerr = 1'b0;
        b_v = '0; x_v = '0; y_v = '0;
        klegal_v = 1'b0; isk_v = 1'b0; a7_v = 1'b0;
        six_v = '0; four_v = '0; six_bal = 1'b0; four_bal = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b_v = din_66b[8*i +: 8];
            x_v = b_v[4:0];
            y_v = b_v[7:5];
            klegal_v = (x_v == 5'd28) || ((y_v == 3'd7) &&
                       (x_v == 5'd23 || x_v == 5'd27 || x_v == 5'd29 || x_v == 5'd30));
            isk_v = kin && klegal_v;
            if (kin && !klegal_v)
                enc_kerr = 1'b1;
            six_v   = (isk_v && x_v == 5'd28) ? 6'b001111 : enc6(x_v);
            six_bal = ($countones(six_v) == 3);
            // D.7 is balanced but still alternates with RD
            if (enc_rd && (!six_bal || x_v == 5'd7))
                six_v = ~six_v;
            if (!six_bal)
                enc_rd = ~enc_rd;
            a7_v = !isk_v && (y_v == 3'd7) &&
                   ((!enc_rd && (x_v == 5'd17 || x_v == 5'd18 || x_v == 5'd20)) ||
                    ( enc_rd && (x_v == 5'd11 || x_v == 5'd13 || x_v == 5'd14)));
            four_v   = a7_v ? 4'b0111 : enc4(y_v, isk_v);
            four_bal = ($countones(four_v) == 2);
            if (enc_rd && (isk_v || !four_bal || y_v == 3'd3))
                four_v = ~four_v;
            if (!four_bal)
                enc_rd = ~enc_rd;
            enc_word[10*i +: 10] = {six_v, four_v};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_8b10 <= '0;
            kin_err   <= 1'b0;
            rd_q      <= 1'b0;
        end else if (en) begin
            dout_8b10 <= enc_word;
            kin_err   <= enc_kerr;
            rd_q      <= enc_rd;
        end
    end

    logic [79:0] flip_mask;
    logic        unused_bits;
    assign unused_bits = ^{din_66b[65:64], error_injection_enable};

`ifdef ERR_INJ_EN
    logic [15:0] lfsr;
    logic [6:0]  flip_pos;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign flip_pos  = (lfsr[6:0] >= 7'd80) ? (lfsr[6:0] - 7'd80) : lfsr[6:0];
    assign flip_mask = error_injection_enable ? (80'd1 << flip_pos) : '0;
`else
    logic [15:0] unused_seed;
    assign unused_seed = LFSR_SEED;
    assign flip_mask   = '0;
`endif

    // Symbol must carry 4..6 ones; non-neutral symbols must alternate sign
    logic       chk_err;
    logic       have_last;
    logic       last_pos;
    logic [3:0] ones_v;

    always_comb begin
        chk_err   = 1'b0;
        have_last = 1'b0;
        last_pos  = 1'b0;
        ones_v    = '0;
        for (int i = 0; i < 8; i++) begin
            ones_v = 4'($countones(corrupted_data[10*i +: 10]));
            if (ones_v < 4'd4 || ones_v > 4'd6) begin
                chk_err = 1'b1;
            end else if (ones_v != 4'd5) begin
                if (have_last && (last_pos == (ones_v == 4'd6)))
                    chk_err = 1'b1;
                have_last = 1'b1;
                last_pos  = (ones_v == 4'd6);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            corrupted_data <= '0;
            disp_err       <= 1'b0;
        end else begin
            corrupted_data <= dout_8b10 ^ flip_mask;
            disp_err       <= chk_err;
        end
    end

endmodule

// File: tb/tb_enc66_to_8b10b_inj.sv
// tb/tb_enc66_to_8b10b_inj.sv - directed self-checking bench for enc66_to_8b10b_inj.
module tb_enc66_to_8b10b_inj;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [65:0] din_66b;
    logic        kin;
    logic        error_injection_enable;
    logic [79:0] dout_8b10;
    logic        disp_err;
    logic        kin_err;
    logic [79:0] corrupted_data;

    int checks = 0;
    int errors = 0;

    localparam logic [9:0] D0_0_N  = 10'b1001110100;
    localparam logic [9:0] D0_0_P  = 10'b0110001011;
    localparam logic [9:0] D31_7_N = 10'b1010110001;
    localparam logic [9:0] K28_5_N = 10'b0011111010;
    localparam logic [9:0] K28_5_P = 10'b1100000101;

    always #5 clk = ~clk;

    enc66_to_8b10b_inj dut (
        .clk                    (clk),
        .rst                    (rst),
        .en                     (en),
        .din_66b                (din_66b),
        .kin                    (kin),
        .error_injection_enable (error_injection_enable),
        .dout_8b10              (dout_8b10),
        .disp_err               (disp_err),
        .kin_err                (kin_err),
        .corrupted_data         (corrupted_data)
    );

    task automatic chk80(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [65:0] d, input logic k);
        din_66b = d;
        kin     = k;
        en      = 1'b1;
        tick();
        en      = 1'b0;
    endtask

    function automatic logic [79:0] rep8(input logic [9:0] s);
        return {8{s}};
    endfunction

    // Independent disparity rule model for the checker output
    function automatic logic disp_model(input logic [79:0] w);
        logic bad = 1'b0;
        int   prev = 0;
        for (int i = 0; i < 8; i++) begin
            int d = 2 * $countones(w[10*i +: 10]) - 10;
            if (d != 0 && d != 2 && d != -2) bad = 1'b1;
            else if (d != 0) begin
                if (prev == d) bad = 1'b1;
                prev = d;
            end
        end
        return bad;
    endfunction

    initial begin
        logic [79:0] prev_corr;
        logic [79:0] diff;
        int          pos;
        int          last_pos;
        int          changes;

        rst = 1'b0; en = 1'b0; kin = 1'b0; din_66b = '0; error_injection_enable = 1'b0;
        repeat (2) tick();
        chk80("reset_dout", dout_8b10, 80'd0);
        chk80("reset_corr", corrupted_data, 80'd0);
        chk1("reset_disp_err", disp_err, 1'b0);
        chk1("reset_kin_err", kin_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        load(66'h0, 1'b0);
        chk80("d0_0", dout_8b10, rep8(D0_0_N));
        chk1("d0_0_kin_err", kin_err, 1'b0);
        tick();
        chk80("d0_0_corr", corrupted_data, rep8(D0_0_N));
        tick();
        chk1("d0_0_disp_err", disp_err, 1'b0);

        load(66'h1_FFFF_FFFF_FFFF_FFFF, 1'b0);
        chk80("d31_7", dout_8b10, rep8(D31_7_N));
        tick();
        tick();
        chk1("d31_7_disp_err", disp_err, 1'b0);

        din_66b = 66'h2_0000_0000_1234_5678;
        kin = 1'b1;
        tick();
        chk80("hold_dout", dout_8b10, rep8(D31_7_N));
        chk1("hold_kin_err", kin_err, 1'b0);

        load(66'h0_0000_0000_0000_EBF1, 1'b0);
        chk80("a7_mix", dout_8b10,
              {{6{D0_0_N}}, 10'b1101001000, 10'b1000110111});

        load(66'h3_F100_0000_0000_0000, 1'b0);
        chk80("end_rd_pos", dout_8b10, {10'b1000110111, {7{D0_0_N}}});
        load(66'h0, 1'b0);
        chk80("start_rd_pos", dout_8b10, rep8(D0_0_P));

        rst = 1'b0;
        #1;
        chk80("reset2_dout", dout_8b10, 80'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        load(66'h0_BCBC_BCBC_BCBC_BCBC, 1'b1);
        chk80("k28_5", dout_8b10, {4{K28_5_P, K28_5_N}});
        chk1("k28_5_kin_err", kin_err, 1'b0);
        tick();
        tick();
        chk1("k28_5_disp_err", disp_err, 1'b0);

        load(66'h0, 1'b1);
        chk1("bad_k_kin_err", kin_err, 1'b1);
        chk80("bad_k_dout", dout_8b10, rep8(D0_0_N));

        load(66'h0_BCBC_BCBC_BCBC_F7FC, 1'b1);
        chk80("k_x7_mix", dout_8b10,
              {{3{K28_5_P, K28_5_N}}, 10'b1110101000, 10'b0011111000});
        chk1("k_x7_kin_err", kin_err, 1'b0);

        load(66'h0, 1'b0);
        tick();
        chk80("inj_pre_corr", corrupted_data, rep8(D0_0_N));
        error_injection_enable = 1'b1;
        prev_corr = corrupted_data;
        last_pos  = -1;
        changes   = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk80("inj_dout_stable", dout_8b10, rep8(D0_0_N));
`ifdef ERR_INJ_EN
            diff = dout_8b10 ^ corrupted_data;
            chk_int("inj_popcount", $countones(diff), 1);
            chk1("inj_disp_err", disp_err, disp_model(prev_corr));
            pos = -1;
            for (int b = 0; b < 80; b++)
                if (diff[b]) pos = b;
            if (last_pos >= 0 && pos != last_pos) changes++;
            last_pos = pos;
`else
            chk80("inj_ignored_corr", corrupted_data, rep8(D0_0_N));
            chk1("inj_ignored_disp_err", disp_err, 1'b0);
`endif
            prev_corr = corrupted_data;
        end
`ifdef ERR_INJ_EN
        checks++;
        assert (changes > 0) else begin
            errors++;
            $error("FAIL inj_pos_varies: observed %0d changes expected >0", changes);
        end
`endif

        #2;
        rst = 1'b0;
        #1;
        chk80("midreset_dout", dout_8b10, 80'd0);
        chk80("midreset_corr", corrupted_data, 80'd0);
        chk1("midreset_disp_err", disp_err, 1'b0);
        chk1("midreset_kin_err", kin_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        error_injection_enable = 1'b0;
        #1;
        load(66'h0, 1'b0);
        chk80("reload_d0_0", dout_8b10, rep8(D0_0_N));
        tick();
        chk80("reload_corr", corrupted_data, rep8(D0_0_N));
        tick();
        chk1("reload_disp_err", disp_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
